// File: rtl/tpu_host_pkg.sv
// Shared definitions for the TPU UART host: opcodes, FSM state type and
// per-opcode frame length helpers.
package tpu_host_pkg;

  localparam logic [7:0] OP_WEIGHT = 8'h01;
  localparam logic [7:0] OP_ACT    = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] OP_RESULT = 8'h05;

  typedef enum logic [2:0] {
    StIdle,
    StSendOp,
    StSendArg,
    StWaitRsp,
    StDone
  } host_state_t;

  // Number of payload bytes that follow the opcode byte.
  function automatic logic [1:0] op_payload_len(input logic [7:0] op);
    unique case (op)
      OP_WEIGHT, OP_ACT: op_payload_len = 2'd2;
      default:           op_payload_len = 2'd0;
    endcase
  endfunction

  // Number of response bytes the TPU returns for this opcode.
  function automatic logic [2:0] op_rsp_len(input logic [7:0] op);
    unique case (op)
      OP_STATUS: op_rsp_len = 3'd2;
      OP_RESULT: op_rsp_len = 3'd4;
      default:   op_rsp_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tpu_uart_host.sv
// Host-side command initiator: serialises one command into opcode/payload
// bytes for a UART PHY and gathers the big-endian response with a timeout.
module tpu_uart_host
  import tpu_host_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        stray_rx,
  output logic        busy
);

  localparam int unsigned TmoW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(RSP_TIMEOUT - 1);

  host_state_t     state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [15:0]     arg_q, arg_d;
  logic [1:0]      pay_q, pay_d;
  logic [2:0]      rcnt_q, rcnt_d;
  logic [31:0]     acc_q, acc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timed_out;

  logic            cmd_ready_q, tx_valid_q, rsp_valid_q, rsp_timeout_q, stray_q, busy_q;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [31:0]     rsp_data_q;

  // Next-state, latched command fields, accumulator and timeout counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    pay_d     = pay_q;
    rcnt_d    = rcnt_q;
    acc_d     = acc_q;
    tmo_d     = tmo_q;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          arg_d   = cmd_arg;
          pay_d   = op_payload_len(cmd_op);
          rcnt_d  = op_rsp_len(cmd_op);
          acc_d   = '0;
          state_d = StSendOp;
        end
      end
      StSendOp: begin
        if (tx_ready) begin
          tmo_d = TmoLoad;
          if (pay_q != 2'd0)       state_d = StSendArg;
          else if (rcnt_q != 3'd0) state_d = StWaitRsp;
          else                     state_d = StDone;
        end
      end
      StSendArg: begin
        if (tx_ready) begin
          pay_d = pay_q - 2'd1;
          tmo_d = TmoLoad;
          if (pay_q == 2'd1) state_d = (rcnt_q != 3'd0) ? StWaitRsp : StDone;
        end
      end
      StWaitRsp: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          acc_d  = {acc_q[23:0], rx_data};
          rcnt_d = rcnt_q - 3'd1;
          tmo_d  = TmoLoad;
          if (rcnt_q == 3'd1) state_d = StDone;
        end else if (tmo_q == '0) begin
          timed_out = 1'b1;
          state_d   = StDone;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte presented to the PHY in the next cycle; held while not accepted.
  always_comb begin
    tx_data_d = tx_data_q;
    if (state_d == StSendOp)       tx_data_d = op_d;
    else if (state_d == StSendArg) tx_data_d = (pay_d == 2'd2) ? arg_d[15:8] : arg_d[7:0];
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      arg_q         <= '0;
      pay_q         <= '0;
      rcnt_q        <= '0;
      acc_q         <= '0;
      tmo_q         <= '0;
      cmd_ready_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      arg_q         <= arg_d;
      pay_q         <= pay_d;
      rcnt_q        <= rcnt_d;
      acc_q         <= acc_d;
      tmo_q         <= tmo_d;
      cmd_ready_q   <= (state_d == StIdle);
      tx_valid_q    <= (state_d == StSendOp) || (state_d == StSendArg);
      tx_data_q     <= tx_data_d;
      rsp_valid_q   <= (state_d == StDone);
      if (state_d == StDone) rsp_data_q <= acc_d;
      rsp_timeout_q <= (state_d == StDone) && timed_out;
      stray_q       <= rx_valid && (state_q != StWaitRsp);
      busy_q        <= (state_d != StIdle);
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign stray_rx    = stray_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tpu_uart_host.sv
// Directed bench for tpu_uart_host with a short response timeout.
module tb_tpu_uart_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        stray_rx;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tpu_uart_host #(.RSP_TIMEOUT(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .stray_rx    (stray_rx),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tx_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset held for three edges.
    repeat (3) tick();
    chk("rst_rdy",   32'(cmd_ready),   32'd0);
    chk("rst_txv",   32'(tx_valid),    32'd0);
    chk("rst_txd",   32'(tx_data),     32'd0);
    chk("rst_rspv",  32'(rsp_valid),   32'd0);
    chk("rst_rspd",  rsp_data,         32'd0);
    chk("rst_tmo",   32'(rsp_timeout), 32'd0);
    chk("rst_stray", 32'(stray_rx),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    rst = 1'b0;
    tick();
    idle_chk("post_rst");

    // OP_ACT 0x12AB, PHY always ready.
    cmd_valid = 1'b1; cmd_op = 8'h02; cmd_arg = 16'h12AB; tx_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tx_chk("act_op", 8'h02);
    chk("act_busy", 32'(busy), 32'd1);
    chk("act_rdy", 32'(cmd_ready), 32'd0);
    tick(); tx_chk("act_hi", 8'h12);
    tick(); tx_chk("act_lo", 8'hAB);
    tick();
    chk("act_rspv", 32'(rsp_valid), 32'd1);
    chk("act_rspd", rsp_data, 32'd0);
    chk("act_txv", 32'(tx_valid), 32'd0);
    chk("act_tmo", 32'(rsp_timeout), 32'd0);
    tick(); idle_chk("act_end");

    // OP_WEIGHT 0x0155 with the PHY stalling every other cycle.
    cmd_valid = 1'b1; cmd_op = 8'h01; cmd_arg = 16'h0155; tx_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tx_chk("wt_op", 8'h01);
    tick(); tx_chk("wt_op_hold", 8'h01);
    tx_ready = 1'b1; tick(); tx_chk("wt_hi", 8'h01);
    tx_ready = 1'b0; tick(); tx_chk("wt_hi_hold", 8'h01);
    tx_ready = 1'b1; tick(); tx_chk("wt_lo", 8'h55);
    tx_ready = 1'b0; tick(); tx_chk("wt_lo_hold", 8'h55);
    chk("wt_no_rsp", 32'(rsp_valid), 32'd0);
    tx_ready = 1'b1; tick();
    chk("wt_rspv", 32'(rsp_valid), 32'd1);
    chk("wt_rspd", rsp_data, 32'd0);
    tick(); idle_chk("wt_end");

    // OP_RESULT, four bytes with 10-cycle gaps.
    cmd_valid = 1'b1; cmd_op = 8'h05; cmd_arg = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    tx_chk("res_op", 8'h05);
    tick();
    chk("res_wait_txv", 32'(tx_valid), 32'd0);
    chk("res_wait_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (10) tick();
      rx_valid = 1'b1;
      case (i)
        0: rx_data = 8'hDE;
        1: rx_data = 8'hAD;
        2: rx_data = 8'hBE;
        default: rx_data = 8'hEF;
      endcase
      tick();
      rx_valid = 1'b0;
      if (i == 2) chk("res_early_rspv", 32'(rsp_valid), 32'd0);
    end
    chk("res_rspv", 32'(rsp_valid), 32'd1);
    chk("res_rspd", rsp_data, 32'hDEADBEEF);
    chk("res_tmo", 32'(rsp_timeout), 32'd0);
    chk("res_stray", 32'(stray_rx), 32'd0);
    tick(); idle_chk("res_end");

    // OP_STATUS with only one byte: timeout 50 cycles after it.
    cmd_valid = 1'b1; cmd_op = 8'h04;
    tick();
    cmd_valid = 1'b0;
    tx_chk("st_op", 8'h04);
    tick();
    rx_valid = 1'b1; rx_data = 8'h05;
    tick();
    rx_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("st_latency", 32'(n), 32'd50);
    chk("st_rspv", 32'(rsp_valid), 32'd1);
    chk("st_tmo", 32'(rsp_timeout), 32'd1);
    chk("st_rspd", rsp_data, 32'h00000005);
    tick(); idle_chk("st_end");
    chk("st_tmo_clr", 32'(rsp_timeout), 32'd0);

    // Stray byte while idle.
    rx_valid = 1'b1; rx_data = 8'h33;
    tick();
    rx_valid = 1'b0;
    chk("stray_pulse", 32'(stray_rx), 32'd1);
    idle_chk("stray_idle");
    tick();
    chk("stray_clr", 32'(stray_rx), 32'd0);
    idle_chk("stray_after");

    // Reset while sending the payload.
    cmd_valid = 1'b1; cmd_op = 8'h02; cmd_arg = 16'h12AB;
    tick();
    cmd_valid = 1'b0;
    tick(); tx_chk("ab_hi", 8'h12);
    rst = 1'b1;
    tick();
    chk("ab_txv", 32'(tx_valid), 32'd0);
    chk("ab_rspv", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    idle_chk("ab_rel");
    tick();
    idle_chk("ab_end");
    chk("ab_txv2", 32'(tx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
